// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential six-digit BCD to binary converter (optional BCD_DIGIT_CHECK_EN)
module bcd_to_binary_seq #(
  parameter int NUM_DIGITS = 6,
  parameter int OUT_W      = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       d1,
  input  logic [3:0]       d2,
  input  logic [3:0]       d3,
  input  logic [3:0]       d4,
  input  logic [3:0]       d5,
  input  logic [3:0]       d6,
  output logic [OUT_W-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             invalid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [OUT_W+3:0] MAX_VAL = {4'b0000, {OUT_W{1'b1}}};
  localparam logic [OUT_W+3:0] TEN     = (OUT_W+4)'(10);
  localparam logic [2:0]       IDX_TOP = 3'(NUM_DIGITS - 1);

  state_t           state_q, state_d;
  logic [3:0]       dig_q [6];
  logic [3:0]       dig_d [6];
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [2:0]       idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] binary_q, binary_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
`ifdef BCD_DIGIT_CHECK_EN
  logic             inv_q, inv_d;
  logic             invalid_q, invalid_d;
`endif

  logic [3:0]       cur_dig;
  logic [OUT_W+3:0] nxt;
  logic             step_ovf;

  // Next-state, accumulate step and registered-output preparation
  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    binary_d   = binary_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
`ifdef BCD_DIGIT_CHECK_EN
    inv_d      = inv_q;
    invalid_d  = invalid_q;
`endif

    // One multiply-by-10 step; the 4 extra bits hold acc*10+15 without wrapping
    cur_dig  = dig_q[idx_q];
    nxt      = ({4'b0000, acc_q} * TEN) + {{OUT_W{1'b0}}, cur_dig};
    step_ovf = (nxt > MAX_VAL);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dig_d[0] = d1;
          dig_d[1] = d2;
          dig_d[2] = d3;
          dig_d[3] = d4;
          dig_d[4] = d5;
          dig_d[5] = d6;
          acc_d    = '0;
          ovf_d    = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
          inv_d    = 1'b0;
`endif
          idx_d    = IDX_TOP;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        // Clamp to all ones once the range is exceeded so later steps cannot wrap
        acc_d = step_ovf ? {OUT_W{1'b1}} : nxt[OUT_W-1:0];
        ovf_d = ovf_q | step_ovf;
`ifdef BCD_DIGIT_CHECK_EN
        inv_d = inv_q | (cur_dig > 4'd9);
`endif
        if (idx_q == 3'd0) begin
          // Results are loaded on the last step so they appear with done
          state_d = S_DONE;
          done_d  = 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
          invalid_d = 1'b0;
          if (inv_d) begin
            binary_d   = '0;
            overflow_d = 1'b0;
            invalid_d  = 1'b1;
          end else
`endif
          if (ovf_d) begin
            binary_d   = {OUT_W{1'b1}};
            overflow_d = 1'b1;
          end else begin
            binary_d   = acc_d;
            overflow_d = 1'b0;
          end
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < 6; i++) dig_q[i] <= 4'd0;
      acc_q      <= '0;
      idx_q      <= 3'd0;
      ovf_q      <= 1'b0;
      binary_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      inv_q      <= 1'b0;
      invalid_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < 6; i++) dig_q[i] <= dig_d[i];
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      binary_q   <= binary_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
`ifdef BCD_DIGIT_CHECK_EN
      inv_q      <= inv_d;
      invalid_q  <= invalid_d;
`endif
    end
  end

  assign binary   = binary_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign invalid  = invalid_q;
`else
  assign invalid  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - self-checking bench for bcd_to_binary_seq
module tb_bcd_to_binary_seq;

`ifdef BCD_DIGIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] d1, d2, d3, d4, d5, d6;
  logic [9:0] binary;
  logic       busy, done, overflow, invalid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] prev_bin;

  typedef struct {
    logic [23:0] digs;
    logic [9:0]  exp_bin;
    logic        exp_ovf;
    logic        exp_inv;
  } vec_t;

  vec_t vecs [9];

  bcd_to_binary_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .d4       (d4),
    .d5       (d5),
    .d6       (d6),
    .binary   (binary),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Decimal value computed as plain arithmetic; any over-range prefix implies an over-range total
  function automatic void model(input logic [23:0] digs, output logic [9:0] b,
                                output logic o, output logic i);
    int  v;
    bit  bad;
    v = 0;
    bad = 1'b0;
    for (int k = 5; k >= 0; k--) begin
      v = v * 10 + int'(digs[k*4 +: 4]);
      if (digs[k*4 +: 4] > 4'd9) bad = 1'b1;
    end
    if (CHK && bad) begin
      b = 10'd0; o = 1'b0; i = 1'b1;
    end else if (v > 1023) begin
      b = 10'd1023; o = 1'b1; i = 1'b0;
    end else begin
      b = v[9:0]; o = 1'b0; i = 1'b0;
    end
  endfunction

  task automatic set_digs(input logic [23:0] digs);
    d1 = digs[3:0];   d2 = digs[7:4];   d3 = digs[11:8];
    d4 = digs[15:12]; d5 = digs[19:16]; d6 = digs[23:20];
  endtask

  // Pulses start for one cycle; returns at the cycle-1 sample point with digits scrambled
  task automatic start_conv(input logic [23:0] digs);
    @(negedge clk);
    set_digs(digs);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_digs(24'($urandom));
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    bit busy_ok, held_ok;
    cyc = 1;
    busy_ok = 1'b1;
    held_ok = 1'b1;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (binary !== prev_bin) held_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    check({tag, " latency"}, cyc, 7);
    check({tag, " busy"}, 32'(busy_ok), 1);
    check({tag, " held"}, 32'(held_ok), 1);
  endtask

  task automatic check_result(input string tag, input logic [9:0] b, input logic o, input logic i);
    check({tag, " binary"}, 32'(binary), 32'(b));
    check({tag, " overflow"}, 32'(overflow), 32'(o));
    check({tag, " invalid"}, 32'(invalid), 32'(i));
    prev_bin = b;
  endtask

  initial begin
    logic [9:0]  mb;
    logic        mo, mi;
    logic [23:0] digs;
    int          cyc;
    bit          seen;

    vecs[0] = '{24'h000023, 10'd23,   1'b0, 1'b0};
    vecs[1] = '{24'h001023, 10'd1023, 1'b0, 1'b0};
    vecs[2] = '{24'h001024, 10'd1023, 1'b1, 1'b0};
    vecs[3] = '{24'h999999, 10'd1023, 1'b1, 1'b0};
    vecs[4] = '{24'h000000, 10'd0,    1'b0, 1'b0};
    vecs[5] = '{24'h000999, 10'd999,  1'b0, 1'b0};
`ifdef BCD_DIGIT_CHECK_EN
    vecs[6] = '{24'h000A00, 10'd0,    1'b0, 1'b1};
    vecs[7] = '{24'h00F000, 10'd0,    1'b0, 1'b1};
    vecs[8] = '{24'h0A0000, 10'd0,    1'b0, 1'b1};
`else
    vecs[6] = '{24'h000A00, 10'd1000, 1'b0, 1'b0};
    vecs[7] = '{24'h00F000, 10'd1023, 1'b1, 1'b0};
    vecs[8] = '{24'h0A0000, 10'd1023, 1'b1, 1'b0};
`endif

    reset = 1'b1;
    start = 1'b0;
    set_digs(24'h0);
    prev_bin = 10'd0;
    repeat (3) @(negedge clk);
    check("reset binary", 32'(binary), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset overflow", 32'(overflow), 0);
    check("reset invalid", 32'(invalid), 0);
    reset = 1'b0;

    // Directed vector table
    foreach (vecs[k]) begin
      start_conv(vecs[k].digs);
      wait_done($sformatf("vec%0d", k));
      check_result($sformatf("vec%0d", k), vecs[k].exp_bin, vecs[k].exp_ovf, vecs[k].exp_inv);
      @(negedge clk);
      check($sformatf("vec%0d done pulse", k), 32'(done), 0);
      check($sformatf("vec%0d idle busy", k), 32'(busy), 0);
    end

    // start during CONV and DONE with other digits is ignored
    start_conv(24'h000123);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      if (cyc == 3) begin start = 1'b1; set_digs(24'h000456); end
      if (cyc == 4) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("ignore latency", cyc, 7);
    check_result("ignore", 10'd123, 1'b0, 1'b0);
    start = 1'b1;
    set_digs(24'h000789);
    @(negedge clk);
    start = 1'b0;
    check("ignore after done busy", 32'(busy), 0);
    @(negedge clk);
    check("ignore no restart busy", 32'(busy), 0);

    // Back-to-back: restart in the cycle right after done
    start_conv(24'h000042);
    wait_done("b2b first");
    check_result("b2b first", 10'd42, 1'b0, 1'b0);
    start_conv(24'h000777);
    wait_done("b2b second");
    check_result("b2b second", 10'd777, 1'b0, 1'b0);

    // Reset in cycle 3 aborts without a done pulse
    start_conv(24'h000555);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort binary", 32'(binary), 0);
    check("abort busy", 32'(busy), 0);
    check("abort done", 32'(done), 0);
    check("abort overflow", 32'(overflow), 0);
    prev_bin = 10'd0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("abort no done", 32'(seen), 0);
    start_conv(24'h000314);
    wait_done("post abort");
    check_result("post abort", 10'd314, 1'b0, 1'b0);

    // Randomised conversions against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      digs = 24'd0;
      for (int k = 0; k < 6; k++) begin
        if (k < 3 || $urandom_range(0, 3) == 0)
          digs[k*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
      end
      model(digs, mb, mo, mi);
      start_conv(digs);
      wait_done($sformatf("rnd%0d", r));
      check_result($sformatf("rnd%0d %h", r, digs), mb, mo, mi);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the team's binary-to-BCD digit splitter.
- Accepts six BCD digits d1 (ones) .. d6 (hundred-thousands) and produces a binary value, one digit per clock, by multiply-by-10 accumulate.
- Sits between the digit entry/display path and the arithmetic datapath, so user-entered decimal values become operands.
- Uses a start/busy/done handshake; flags overflow and invalid digits.

Parameters:
- NUM_DIGITS, 6, number of BCD digit inputs processed (fixed port set d1..d6; digits above NUM_DIGITS are ignored).
- OUT_W, 10, binary output width; maximum representable value is 2^OUT_W-1 (1023 at default).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- d1..d6  input  4 each  BCD digits; d1 = ones, d6 = most significant.
- binary  output  OUT_W  converted value; held until the next done.
- busy  output  1  high in CONV and DONE.
- done  output  1  one-cycle pulse when results update.
- overflow  output  1  value exceeded 2^OUT_W-1; held with binary.
- invalid  output  1  some digit > 9; held with binary.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; binary=0, busy=0, done=0, overflow=0, invalid=0; internal accumulator and index cleared. Reset mid-conversion aborts, with no done pulse.
- States: IDLE, CONV, DONE.
- IDLE: on start=1, register d1..d6 into a digit shadow, set acc=0, ovf_s=0, inv_s=0, idx=NUM_DIGITS-1, and go to CONV. Input digits may change after the start cycle.
- CONV: one digit per cycle, from most significant (d6) to least significant (d1).
  - Step: nxt = acc*10 + digit[idx], computed in OUT_W+4 bits.
  - If digit > 9, set inv_s.
  - If nxt > 2^OUT_W-1, set ovf_s and store acc = 2^OUT_W-1 (clamped, so it never wraps). Otherwise store acc = nxt.
  - After idx=0 is processed, go to DONE.
- DONE (one cycle):
  - done=1.
  - If inv_s: binary=0, invalid=1, overflow=0. Invalid takes priority.
  - Else if ovf_s: binary=all ones, overflow=1, invalid=0.
  - Else: binary=acc, both flags 0.
  - Next state is IDLE.
- Latency: start accepted at edge 0; CONV occupies NUM_DIGITS cycles; done is high in cycle NUM_DIGITS+1 (cycle 7 at default).
- Earliest accepted restart is the cycle after done.
- start while busy (CONV or DONE) is ignored, not queued.
- busy: 1 in CONV and DONE, 0 in IDLE.
- All outputs are registered; done is 0 outside DONE.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined: digit-validity check is active as described; invalid is asserted for any digit > 9, and binary is forced to 0.
- Undefined: no check; digits 10..15 are accumulated with their raw value (overflow rules still apply); invalid is tied to 0 and its register is removed.

Test Plan:
- Digits 0,0,0,0,2,3 (d6..d1) + start pulse -> done in cycle 7, binary=23 (10'b0000010111), overflow=0, invalid=0, busy high for cycles 1..7.
- Digits 0,0,1,0,2,3 -> binary=1023, overflow=0; then digits 0,0,1,0,2,4 -> binary=1023, overflow=1.
- Digits 9,9,9,9,9,9 -> overflow=1, binary=1023, with no wrap (check clamp at every step).
- d3=4'hA, others 0 -> with BCD_DIGIT_CHECK_EN: invalid=1, binary=0. Without the macro: binary=1000, invalid=0.
- start re-asserted during CONV and during DONE with different digits -> ignored; result reflects the first digits. start the cycle after done -> new conversion, done 7 cycles later.
- reset asserted in cycle 3 of a conversion -> all outputs 0 the next cycle, no done pulse; a new start then converts correctly.
